// File: rtl/ins_wb_pkg.sv
// Shared types and defaults for the write-back/commit stage.
package ins_wb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MEM    = 2'd1,
    S_COMMIT = 2'd2
  } wb_state_e;

  localparam int BYTES_DEF  = 4;
  localparam int ADDR_W_DEF = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/ins_wb_mem_byte_ser.sv
// Serialises one store word into little-endian byte writes on a req/ack bus.
module mem_byte_ser #(
  parameter int BYTES  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [BYTES*8-1:0]   val,
  input  logic                 mem_ack,
  output logic                 busy,
  output logic                 last_ack,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [7:0]           mem_byte
);

  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);

  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BYTES*8-1:0] val_q, val_d;

  always_comb begin
    last_ack   = busy_q && mem_ack && (byte_cnt_q == CNT_LAST);
    busy_d     = busy_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    val_d      = val_q;
    if (start) begin
      busy_d     = 1'b1;
      byte_cnt_d = '0;
      addr_d     = addr;
      val_d      = val;
    end else if (last_ack) begin
      busy_d     = 1'b0;
    end else if (busy_q && mem_ack) begin
      byte_cnt_d = byte_cnt_q + CNT_W'(1);
    end
  end

  // Control state: reset
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      busy_q     <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // Store word and base address: only meaningful while busy, so no reset
  always_ff @(posedge sys_clk) begin
    addr_q <= addr_d;
    val_q  <= val_d;
  end

  always_comb begin
    busy     = busy_q;
    mem_addr = busy_q ? (addr_q + ADDR_W'(byte_cnt_q)) : '0;
    mem_byte = busy_q ? val_q[8*byte_cnt_q +: 8] : 8'h00;
  end

endmodule

// File: rtl/ins_wb.sv
// Write-back/commit stage: applies register, PC and store effects of one
// executed instruction, stalling execute while a store drains byte by byte.
module ins_wb
  import ins_wb_pkg::*;
#(
  parameter int BYTES  = BYTES_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                reg_w_op,
  input  logic [4:0]          reg_w_reg_idx,
  input  logic [31:0]         reg_w_reg_val,
  input  logic                mem_w_op,
  input  logic [ADDR_W-1:0]   mem_w_mem_addr,
  input  logic [BYTES*8-1:0]  mem_w_mem_val,
  input  logic                reg_pc_w_op,
  input  logic [31:0]         reg_pc_w_val,
  output logic                rf_we,
  output logic [4:0]          rf_idx,
  output logic [31:0]         rf_val,
  output logic                pc_we,
  output logic [31:0]         pc_val,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [7:0]          mem_byte,
  input  logic                mem_ack,
  output logic                commit
);

  wb_state_e   state_q;
  logic        accept, ser_start, ser_busy, ser_last_ack, in_commit;

  logic        reg_op_q, reg_op_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] rval_q, rval_d;
  logic        pc_op_q, pc_op_d;
  logic [31:0] pcv_q, pcv_d;

  always_comb begin
    accept    = (state_q == S_IDLE) && in_valid;
    ser_start = accept && mem_w_op;
    reg_op_d  = accept ? reg_w_op      : reg_op_q;
    idx_d     = accept ? reg_w_reg_idx : idx_q;
    rval_d    = accept ? reg_w_reg_val : rval_q;
    pc_op_d   = accept ? reg_pc_w_op   : pc_op_q;
    pcv_d     = accept ? reg_pc_w_val  : pcv_q;
  end

  // Latched request: consumed only in COMMIT, so left out of reset
  always_ff @(posedge sys_clk) begin
    reg_op_q <= reg_op_d;
    idx_q    <= idx_d;
    rval_q   <= rval_d;
    pc_op_q  <= pc_op_d;
    pcv_q    <= pcv_d;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (in_valid) state_q <= mem_w_op ? S_MEM : S_COMMIT;
        S_MEM:    if (ser_last_ack) state_q <= S_COMMIT;
        S_COMMIT: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  mem_byte_ser #(
    .BYTES  (BYTES),
    .ADDR_W (ADDR_W)
  ) u_ser (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .start    (ser_start),
    .addr     (mem_w_mem_addr),
    .val      (mem_w_mem_val),
    .mem_ack  (mem_ack),
    .busy     (ser_busy),
    .last_ack (ser_last_ack),
    .mem_addr (mem_addr),
    .mem_byte (mem_byte)
  );

  // Data outputs are gated by state so they read zero whenever no strobe is up
  always_comb begin
    in_commit = (state_q == S_COMMIT);
    in_ready  = (state_q == S_IDLE);
    commit    = in_commit;
    mem_req   = ser_busy;
    rf_we     = in_commit && reg_op_q && (idx_q != REG_ZERO);
    rf_idx    = in_commit ? idx_q  : 5'd0;
    rf_val    = in_commit ? rval_q : 32'd0;
    pc_we     = in_commit && pc_op_q;
    pc_val    = in_commit ? pcv_q  : 32'd0;
  end

endmodule

// File: tb/tb_ins_wb.sv
// Directed bench for ins_wb: ALU, JAL, store serialisation, stalls, wrap, reset.
module tb_ins_wb;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        in_valid, in_ready;
  logic        reg_w_op;
  logic [4:0]  reg_w_reg_idx;
  logic [31:0] reg_w_reg_val;
  logic        mem_w_op;
  logic [31:0] mem_w_mem_addr, mem_w_mem_val;
  logic        reg_pc_w_op;
  logic [31:0] reg_pc_w_val;
  logic        rf_we, pc_we, mem_req, mem_ack, commit;
  logic [4:0]  rf_idx;
  logic [31:0] rf_val, pc_val, mem_addr;
  logic [7:0]  mem_byte;

  int n_vec = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  ins_wb dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .reg_w_op       (reg_w_op),
    .reg_w_reg_idx  (reg_w_reg_idx),
    .reg_w_reg_val  (reg_w_reg_val),
    .mem_w_op       (mem_w_op),
    .mem_w_mem_addr (mem_w_mem_addr),
    .mem_w_mem_val  (mem_w_mem_val),
    .reg_pc_w_op    (reg_pc_w_op),
    .reg_pc_w_val   (reg_pc_w_val),
    .rf_we          (rf_we),
    .rf_idx         (rf_idx),
    .rf_val         (rf_val),
    .pc_we          (pc_we),
    .pc_val         (pc_val),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_byte       (mem_byte),
    .mem_ack        (mem_ack),
    .commit         (commit)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_req();
    in_valid       = 1'b0;
    reg_w_op       = 1'b0;
    reg_w_reg_idx  = 5'd0;
    reg_w_reg_val  = 32'd0;
    mem_w_op       = 1'b0;
    mem_w_mem_addr = 32'd0;
    mem_w_mem_val  = 32'd0;
    reg_pc_w_op    = 1'b0;
    reg_pc_w_val   = 32'd0;
  endtask

  // Presents one request for a single accept edge; returns just after it.
  task automatic send(input logic rop, input logic [4:0] idx, input logic [31:0] rv,
                      input logic mop, input logic [31:0] ma, input logic [31:0] mv,
                      input logic pop, input logic [31:0] pv);
    reg_w_op = rop; reg_w_reg_idx = idx; reg_w_reg_val = rv;
    mem_w_op = mop; mem_w_mem_addr = ma; mem_w_mem_val = mv;
    reg_pc_w_op = pop; reg_pc_w_val = pv;
    in_valid = 1'b1;
    tick();
    clear_req();
  endtask

  // Runs a store; byte 'stall_byte' waits 'stall_n' cycles before its ack.
  task automatic run_store(input string tag, input logic [31:0] addr, input logic [31:0] val,
                           input int stall_byte, input int stall_n);
    int k = 0;
    int nbytes = 0;
    int stalls = 0;
    logic [31:0] ea;
    logic [31:0] ev;
    send(1'b0, 5'd0, 32'd0, 1'b1, addr, val, 1'b0, 32'd0);
    while (k < 40 && !commit) begin
      ea = addr + nbytes;
      ev = val >> (8 * nbytes);
      chk({tag, "_req"}, mem_req, 1'b1);
      chk({tag, "_addr"}, mem_addr, ea);
      chk({tag, "_byte"}, mem_byte, ev[7:0]);
      if (nbytes == stall_byte && stalls < stall_n) begin
        mem_ack = 1'b0;
        stalls++;
      end else begin
        mem_ack = 1'b1;
        nbytes++;
      end
      tick();
      k++;
    end
    mem_ack = 1'b0;
    chk({tag, "_commit"}, commit, 1'b1);
    chk({tag, "_nbytes"}, nbytes, 4);
    chk({tag, "_cycles"}, k + 1, 5 + stall_n);
    chk({tag, "_req_off"}, mem_req, 1'b0);
    chk({tag, "_rfwe"}, rf_we, 1'b0);
    tick();
    chk({tag, "_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    clear_req();
    mem_ack = 1'b0;
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;

    chk("rst_ready", in_ready, 1'b1);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_rfwe", rf_we, 1'b0);
    chk("rst_pcwe", pc_we, 1'b0);
    chk("rst_commit", commit, 1'b0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_rfidx", rf_idx, 5'd0);

    // ADDI x5, 0x1234
    send(1'b1, 5'd5, 32'h1234, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    chk("addi_rfwe", rf_we, 1'b1);
    chk("addi_idx", rf_idx, 5'd5);
    chk("addi_val", rf_val, 32'h1234);
    chk("addi_pcwe", pc_we, 1'b0);
    chk("addi_req", mem_req, 1'b0);
    chk("addi_commit", commit, 1'b1);
    chk("addi_busy", in_ready, 1'b0);
    tick();
    chk("addi_rfwe_off", rf_we, 1'b0);
    chk("addi_commit_off", commit, 1'b0);
    chk("addi_ready", in_ready, 1'b1);

    // No-op request still retires
    send(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    chk("nop_commit", commit, 1'b1);
    chk("nop_rfwe", rf_we, 1'b0);
    chk("nop_pcwe", pc_we, 1'b0);
    tick();

    // JAL x1 then JAL x0
    send(1'b1, 5'd1, 32'h204, 1'b0, 32'd0, 32'd0, 1'b1, 32'h400);
    chk("jal_rfwe", rf_we, 1'b1);
    chk("jal_pcwe", pc_we, 1'b1);
    chk("jal_idx", rf_idx, 5'd1);
    chk("jal_val", rf_val, 32'h204);
    chk("jal_pc", pc_val, 32'h400);
    chk("jal_commit", commit, 1'b1);
    tick();
    send(1'b1, 5'd0, 32'h204, 1'b0, 32'd0, 32'd0, 1'b1, 32'h400);
    chk("jal0_rfwe", rf_we, 1'b0);
    chk("jal0_pcwe", pc_we, 1'b1);
    chk("jal0_pc", pc_val, 32'h400);
    tick();

    run_store("st", 32'h100, 32'hAABBCCDD, -1, 0);
    run_store("stall", 32'h100, 32'hAABBCCDD, 1, 3);
    run_store("wrap", 32'hFFFFFFFE, 32'h11223344, -1, 0);

    // Reset while byte 2 is on the bus
    send(1'b1, 5'd3, 32'h55, 1'b1, 32'h200, 32'h01020304, 1'b1, 32'h800);
    mem_ack = 1'b1;
    tick();
    tick();
    mem_ack = 1'b0;
    chk("rstmid_addr", mem_addr, 32'h202);
    chk("rstmid_byte", mem_byte, 8'h02);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("rstmid_req", mem_req, 1'b0);
    chk("rstmid_commit", commit, 1'b0);
    chk("rstmid_ready", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstmid_post_commit", commit, 1'b0);
      chk("rstmid_post_rfwe", rf_we, 1'b0);
      chk("rstmid_post_pcwe", pc_we, 1'b0);
      chk("rstmid_post_req", mem_req, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
